// File: rtl/recfn_to_fn_arbiter.sv
// recfn_to_fn_arbiter: round-robin sharing of one HardFloat recoded-to-IEEE converter
// behind a capture register and an output register, results tagged with requester id.
module recfn_to_fn_arbiter #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24,
    parameter int NUM_REQ = 4,
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int REC_WIDTH = EXP_WIDTH + SIG_WIDTH + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*REC_WIDTH-1:0]   req_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+SIG_WIDTH-1:0] out_data,
    output logic [ID_WIDTH-1:0]            out_id,
    output logic                           idle
);
    localparam int MIN_NORM = 2**(EXP_WIDTH-1) + 2;
    localparam int DIST_WIDTH = $clog2(SIG_WIDTH);

    logic                           s1_valid_q, s1_valid_d;
    logic [REC_WIDTH-1:0]           s1_data_q, s1_data_d;
    logic [ID_WIDTH-1:0]            s1_id_q, s1_id_d;
    logic                           out_valid_q, out_valid_d;
    logic [EXP_WIDTH+SIG_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]            out_id_q, out_id_d;
    logic [ID_WIDTH-1:0]            ptr_q, ptr_d;

    logic                  s1_en, s2_en, found, accept;
    logic [ID_WIDTH-1:0]   win, idx;

    logic                  c_sign, c_zero, c_nan, c_inf, c_sub;
    logic [EXP_WIDTH:0]    c_exp;
    logic [SIG_WIDTH-2:0]  c_fract, c_fract_out;
    logic [EXP_WIDTH-1:0]  c_exp_out;
    logic [DIST_WIDTH-1:0] c_dist;

    // first valid requester at or after the pointer, wrapping around
    always_comb begin
        win = '0;
        idx = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    assign s2_en = !out_valid_q || out_ready;
    assign s1_en = !s1_valid_q || s2_en;
    assign accept = found && s1_en && !reset;
    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

    // recoded exponent top bits: 000 zero, 110 infinity, 111 NaN
    always_comb begin
        c_sign = s1_data_q[REC_WIDTH-1];
        c_exp = s1_data_q[REC_WIDTH-2 -: EXP_WIDTH+1];
        c_fract = s1_data_q[SIG_WIDTH-2:0];
        c_zero = c_exp[EXP_WIDTH -: 3] == 3'b000;
        c_nan = c_exp[EXP_WIDTH -: 3] == 3'b111;
        c_inf = c_exp[EXP_WIDTH -: 3] == 3'b110;
        c_sub = c_exp < (EXP_WIDTH+1)'(MIN_NORM);
        c_dist = DIST_WIDTH'(MIN_NORM - 1) - c_exp[DIST_WIDTH-1:0];
        c_exp_out = (c_sub ? '0 : c_exp[EXP_WIDTH-1:0] - EXP_WIDTH'(MIN_NORM - 1)) | {EXP_WIDTH{c_nan | c_inf}};
        c_fract_out = c_sub ? ({!c_zero, c_fract[SIG_WIDTH-2:1]} >> c_dist) : (c_inf ? '0 : c_fract);
    end

    always_comb begin
        ptr_d = accept ? ((win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1) : ptr_q;
        s1_valid_d = accept || (s1_valid_q && !s2_en);
        s1_data_d = accept ? req_data[int'(win)*REC_WIDTH +: REC_WIDTH] : s1_data_q;
        s1_id_d = accept ? win : s1_id_q;
        out_valid_d = s2_en ? s1_valid_q : out_valid_q;
        out_data_d = s2_en ? {c_sign, c_exp_out, c_fract_out} : out_data_q;
        out_id_d = s2_en ? s1_id_q : out_id_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q <= '0;
            s1_id_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_id_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q <= s1_data_d;
            s1_id_q <= s1_id_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_id_q <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_id = out_id_q;
    assign idle = !s1_valid_q && !out_valid_q;
endmodule

// File: tb/tb_recfn_to_fn_arbiter.sv
// tb_recfn_to_fn_arbiter: directed scenarios for the shared recoded-to-IEEE converter,
// sampled and driven on the falling clock edge.
module tb_recfn_to_fn_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [131:0] req_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_id;
    logic         idle;
    int n_checks = 0;
    int n_fail = 0;

    recfn_to_fn_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic set_word(input int i, input logic [32:0] w);
        req_data[i*33 +: 33] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
        req_data = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_out_id: got %0d expected 0", out_id); end
        req_valid = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        out_ready = 1'b1;
        req_valid = 4'b0001;
        set_word(0, 33'h0_8000_0000);
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_before: got %b expected 1", idle); end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
        n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: got idle %b expected 0", idle); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_data: got %h expected 3f800000", out_data); end
        n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", out_id); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b expected 0", out_valid); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_after: got %b expected 1", idle); end
    endtask

    task automatic test_specials();
        logic [32:0] w [4];
        logic [31:0] e [4];
        w[0] = 33'h0_0000_0000; e[0] = 32'h0000_0000;
        w[1] = 33'h1_8080_0000; e[1] = 32'hC000_0000;
        w[2] = 33'h0_C000_0000; e[2] = 32'h7F80_0000;
        w[3] = 33'h0_E040_0000; e[3] = 32'h7FC0_0000;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            req_valid = (k < 4) ? 4'b0100 : 4'b0000;
            if (k < 4) set_word(2, w[k]);
            #1;
            if (k < 4) begin
                n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL special_ready[%0d]: got %b expected 0100", k, req_ready); end
            end
            if (k >= 2 && k < 6) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL special_valid[%0d]: got %b expected 1", k-2, out_valid); end
                n_checks++; if (out_data !== e[k-2]) begin n_fail++; $display("FAIL special_data[%0d]: got %h expected %h", k-2, out_data, e[k-2]); end
                n_checks++; if (out_id !== 2'd2) begin n_fail++; $display("FAIL special_id[%0d]: got %0d expected 2", k-2, out_id); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) set_word(i, {1'b0, 9'h100 + 9'(i), 23'h0});
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) begin
                n_checks++; if (req_ready !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'b0001 << (k % 4)); end
            end
            if (k >= 2) begin
                e = 32'h3F80_0000 + (32'((k - 2) % 4) << 23);
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b expected 1", k-2, out_valid); end
                n_checks++; if (out_id !== 2'((k - 2) % 4)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d expected %0d", k-2, out_id, (k - 2) % 4); end
                n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k-2, out_data, e); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] w [5];
        logic [31:0] e [5];
        int j, rcv;
        for (int k = 0; k < 5; k++) begin
            w[k] = {1'b0, 9'h100 + 9'(k), 23'h0};
            e[k] = {1'b0, 8'h7F + 8'(k), 23'h0};
        end
        j = 0;
        rcv = 0;
        for (int c = 0; c < 30 && rcv < 5; c++) begin
            @(negedge clk);
            out_ready = (c >= 6);
            req_valid = (j < 5) ? 4'b0010 : 4'b0000;
            if (j < 5) set_word(1, w[j]);
            #1;
            if (c == 6) begin
                n_checks++; if (j !== 2) begin n_fail++; $display("FAIL bp_accepts_before_stall: got %0d expected 2", j); end
            end
            if (c >= 2 && c < 6) begin
                n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", c, req_ready); end
            end
            if (out_valid) begin
                n_checks++; if (out_data !== e[rcv]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", rcv, out_data, e[rcv]); end
                n_checks++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d expected 1", rcv, out_id); end
                if (out_ready) rcv++;
            end
            if (req_valid[1] && req_ready[1]) j++;
        end
        n_checks++; if (rcv !== 5) begin n_fail++; $display("FAIL bp_received: got %0d expected 5", rcv); end
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate[%0d]: got out_valid %b expected 0", c, out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        req_valid = 4'b0001;
        set_word(0, 33'h0_8000_0000);
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_preload: got out_valid %b expected 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got %b expected 1", idle); end
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b1000;
        set_word(3, 33'h1_8080_0000);
        out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_ready_after: got %b expected 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got out_valid %b expected 0", out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 32'hC000_0000) begin n_fail++; $display("FAIL mid_data: got %h expected c0000000", out_data); end
        n_checks++; if (out_id !== 2'd3) begin n_fail++; $display("FAIL mid_id: got %0d expected 3", out_id); end
    endtask

    task automatic test_fairness();
        int acc;
        bit hit;
        acc = 0;
        hit = 1'b0;
        out_ready = 1'b1;
        set_word(0, 33'h0_8000_0000);
        set_word(3, 33'h0_8080_0000);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = {(c >= 2) && !hit, 2'b00, 1'b1};
            #1;
            if (c == 2) begin
                n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL fair_ready: got %b expected 1000", req_ready); end
            end
            if (req_valid[3] && |(req_valid & req_ready)) acc++;
            if (req_valid[3] && req_ready[3]) hit = 1'b1;
        end
        req_valid = '0;
        n_checks++; if (!hit || acc > 2) begin n_fail++; $display("FAIL fair_bound: got served=%0d after %0d accepts expected served=1 within 2", hit, acc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_specials();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_fairness();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/recfn_to_fn_arbiter.md
Name: recfn_to_fn_arbiter

Overview:
- Shares one recoded-to-IEEE float converter among NUM_REQ requesters.
- Requesters present recoded words (expWidth+sigWidth+1 bits) on valid/ready channels.
- A round-robin arbiter selects one requester per cycle and pushes its word through a 2-stage pipeline (capture register, combinational convert, output register).
- Each result leaves on a single valid/ready output tagged with the originating requester ID. Used wherever several FP units must write standard-format results through one conversion point.

Parameters:
- EXP_WIDTH, 8, exponent width of the IEEE format (recoded exponent is EXP_WIDTH+1).
- SIG_WIDTH, 24, significand width including the hidden bit.
- NUM_REQ, 4, number of requesters, 2..16.
- ID_WIDTH, max(1, clog2(NUM_REQ)), width of the requester tag (derived; not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester valid
- req_ready  out  NUM_REQ  per-requester ready (one-hot or zero)
- req_data  in  NUM_REQ*(EXP_WIDTH+SIG_WIDTH+1)  recoded words; requester i occupies slice i
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  EXP_WIDTH+SIG_WIDTH  IEEE result {sign, exp, fraction}
- out_id  out  ID_WIDTH  requester index of out_data
- idle  out  1  both pipeline stages empty

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted and after it: out_valid=0, req_ready=0, idle=1, out_data=0, out_id=0, RR pointer=0, both stage-valid bits=0. Reset mid-operation discards in-flight words without emitting them.
- Stage advance:
  - s2_en = !out_valid_q || out_ready.
  - s1_en = !s1_valid || s2_en.
- Arbitration (combinational):
  - Search starts at pointer p and proceeds p, p+1, …, NUM_REQ-1, 0, …, p-1. The first asserted req_valid wins.
  - req_ready[win] = s1_en. All other req_ready bits are 0.
  - No requester is ready when nothing is valid.
- Accept: a word is accepted when req_valid[i] && req_ready[i]. On accept, stage 1 captures {req_data slice i, i}, s1_valid=1, and p <= (i+1) mod NUM_REQ.
  - p changes only on accept.
  - A requester holding valid is served within NUM_REQ accepts.
- No accept while s1_en=1: s1_valid <= 0 if stage 1 advances into stage 2; otherwise it holds.
- Stage 2:
  - On s2_en, it loads converted(s1 word) and s1 id, and out_valid <= s1_valid.
  - While out_valid && !out_ready, out_data and out_id are held stable.
- Conversion is bit-exact HardFloat recoded-to-standard:
  - Recoded exponent top 3 bits 000 → zero.
  - 110 → infinity (exp all ones, fraction 0).
  - 111 → NaN (exp all ones, fraction = recoded fraction).
  - Sign is passed through.
  - Subnormals are denormalised by right-shifting {1,fract} by minNormExp-1-sExp.
- Latency: accept in cycle N → out_valid in cycle N+2 with no backpressure. Sustained throughput is 1 result/cycle with out_ready=1.
- Backpressure: with out_ready=0, at most 2 words are in flight. req_ready then drops to 0 until out_ready returns. No word is lost or duplicated.
- Ordering: results emerge in acceptance order.
- Simultaneous events: accept into stage 1 and drain from stage 2 in the same cycle are both legal.
- idle = !s1_valid && !out_valid_q.
- req_data of non-winning requesters is ignored. A requester may drop valid before it is accepted; the arbiter re-evaluates each cycle.

Test Plan:
- Single word: req 0 sends 0x0_8000_0000 (f32 1.0 recoded) with out_ready=1 → two cycles later out_valid=1, out_data=0x3F80_0000, out_id=0; idle returns to 1 the following cycle.
- Specials, back to back on req 2: 0x0_0000_0000, 0x1_8080_0000, 0x0_C000_0000, 0x0_E040_0000 → outputs 0x0000_0000, 0xC000_0000, 0x7F80_0000, 0x7FC0_0000 on consecutive cycles, out_id=2 each.
- Round-robin: all 4 requesters held valid for 8 accepts from p=0 → out_id sequence 0,1,2,3,0,1,2,3.
- Backpressure: stream 5 words from req 1 with out_ready=0 for 6 cycles, then 1 → exactly 2 accepts before stall, then all 5 results in order, none duplicated.
- Reset mid-stream: assert reset asynchronously with 2 words in flight → out_valid and req_ready fall immediately. After release, the next word from req 3 is served first (p=0, only req 3 valid) with a 2-cycle latency.
- Fairness: req 0 held continuously valid, req 3 pulses valid → req 3 is accepted within 2 accepts of asserting valid.
